// File: rtl/ttl245_bus_controller.sv
// ttl245_bus_controller
//
// Control sequencer for one 74LS245 transceiver (DIR, OE_n). It runs a single
// read or write transaction between the local A-side bus and the B-side
// backplane as turnaround -> drive/settle -> capture -> release. DIR only moves
// while the transceiver is disabled. The local A driver is only enabled on writes,
// when DIR points A->B, so it never fights the chip on A.
//
// Parameters
//   WIDTH              data bus width
//   SETTLE_CYCLES      cycles OE_n is held low before capture/ack (>= 1)
//   TURNAROUND_CYCLES  cycles OE_n is held high before enable and after disable (>= 1)
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high reset
//   req     in   start a transaction; only looked at in IDLE
//   write   in   1 = write (A->B), 0 = read (B->A); sampled with req
//   wdata   in   write data; sampled with req
//   a_in    in   A-side bus as seen by this block (read capture)
//   a_out   out  data for the local A-side tristate driver
//   a_oe    out  enable for the local A-side driver
//   dir     out  transceiver DIR: 1 = A->B, 0 = B->A
//   oe_n    out  transceiver OE_n (active low)
//   rdata   out  last captured read data
//   busy    out  high from the cycle after acceptance until back in IDLE
//   ack     out  one-cycle completion pulse (first RELEASE cycle)

module ttl245_bus_controller #(
    parameter int WIDTH             = 8,
    parameter int SETTLE_CYCLES     = 3,
    parameter int TURNAROUND_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             write,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] a_in,
    output logic [WIDTH-1:0] a_out,
    output logic             a_oe,
    output logic             dir,
    output logic             oe_n,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             ack
);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be >= 1");
    end
    if (TURNAROUND_CYCLES < 1) begin : g_bad_turnaround
        $error("TURNAROUND_CYCLES must be >= 1");
    end

    localparam int MaxCycles = (SETTLE_CYCLES > TURNAROUND_CYCLES) ?
                               SETTLE_CYCLES : TURNAROUND_CYCLES;
    localparam int CntW      = $clog2(MaxCycles + 1);

    // The counter holds "cycles remaining after this one", so it loads N-1.
    localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] TurnLoad   = CntW'(TURNAROUND_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StActive, StRelease} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic             oe_n_q, oe_n_d;
    logic             dir_q, dir_d;
    logic             a_oe_q, a_oe_d;
    logic [WIDTH-1:0] a_out_q, a_out_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        oe_n_d  = oe_n_q;
        dir_d   = dir_q;
        a_oe_d  = a_oe_q;
        a_out_d = a_out_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;

        case (state_q)
            StIdle: begin
                oe_n_d = 1'b1;
                a_oe_d = 1'b0;
                if (req) begin
                    state_d = StSetup;
                    cnt_d   = TurnLoad;
                    wr_d    = write;
                    // Transceiver is off here and stays off through SETUP.
                    dir_d   = write;
                    busy_d  = 1'b1;
                    if (write) begin
                        a_oe_d  = 1'b1;
                        a_out_d = wdata;
                    end
                end
            end

            StSetup: begin
                oe_n_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = StActive;
                    cnt_d   = SettleLoad;
                    oe_n_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end

            StActive: begin
                oe_n_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = StRelease;
                    cnt_d   = TurnLoad;
                    oe_n_d  = 1'b1;
                    a_oe_d  = 1'b0;
                    ack_d   = 1'b1;
                    if (!wr_q) begin
                        rdata_d = a_in;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end

            StRelease: begin
                oe_n_d = 1'b1;
                a_oe_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end

            default: begin
                state_d = StIdle;
                oe_n_d  = 1'b1;
                a_oe_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            oe_n_q  <= 1'b1;
            dir_q   <= 1'b0;
            a_oe_q  <= 1'b0;
            a_out_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            oe_n_q  <= oe_n_d;
            dir_q   <= dir_d;
            a_oe_q  <= a_oe_d;
            a_out_q <= a_out_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign a_out = a_out_q;
    assign a_oe  = a_oe_q;
    assign dir   = dir_q;
    assign oe_n  = oe_n_q;
    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign ack   = ack_q;

endmodule

// File: tb/tb_ttl245_bus_controller.sv
// tb_ttl245_bus_controller
//
// Two controllers (default timing, and SETTLE=1/TURNAROUND=2), each with a simple
// behavioural 245 + A-bus model. A per-instance reference model tracks "cycles since
// acceptance" and derives every output from that count each cycle.

module tb_ttl245_bus_controller;

    localparam int W  = 8;
    localparam int T0 = 1;
    localparam int S0 = 3;
    localparam int T1 = 2;
    localparam int S1 = 1;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic [1:0]        reset, req, write;
    logic [1:0][W-1:0] wdata, b_drv, a_bus, a_out, rdata;
    logic [1:0]        a_oe, dir, oe_n, busy, ack;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    // A bus: local driver, or the chip driving B->A, otherwise floating (read as 0).
    assign a_bus[0] = a_oe[0] ? a_out[0] : ((!oe_n[0] && !dir[0]) ? b_drv[0] : '0);
    assign a_bus[1] = a_oe[1] ? a_out[1] : ((!oe_n[1] && !dir[1]) ? b_drv[1] : '0);

    ttl245_bus_controller #(.WIDTH(W), .SETTLE_CYCLES(S0), .TURNAROUND_CYCLES(T0)) u_dut0 (
        .clk(clk), .reset(reset[0]), .req(req[0]), .write(write[0]), .wdata(wdata[0]),
        .a_in(a_bus[0]), .a_out(a_out[0]), .a_oe(a_oe[0]), .dir(dir[0]), .oe_n(oe_n[0]),
        .rdata(rdata[0]), .busy(busy[0]), .ack(ack[0])
    );

    ttl245_bus_controller #(.WIDTH(W), .SETTLE_CYCLES(S1), .TURNAROUND_CYCLES(T1)) u_dut1 (
        .clk(clk), .reset(reset[1]), .req(req[1]), .write(write[1]), .wdata(wdata[1]),
        .a_in(a_bus[1]), .a_out(a_out[1]), .a_oe(a_oe[1]), .dir(dir[1]), .oe_n(oe_n[1]),
        .rdata(rdata[1]), .busy(busy[1]), .ack(ack[1])
    );

    function automatic int tp(input int i);
        return (i == 0) ? T0 : T1;
    endfunction

    function automatic int sp(input int i);
        return (i == 0) ? S0 : S1;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[dut%0d] @%0t: got %0h, expected %0h", name, idx, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int             phase;  // 0 = idle, else cycle number since acceptance
        logic           wr;
        logic           dir;
        logic [W-1:0]   a_out;
        logic [W-1:0]   rdata;
    } model_t;

    model_t m [2];

    function automatic model_t step(input model_t mi, input logic rst, input logic rq,
                                    input logic w, input logic [W-1:0] wd,
                                    input logic [W-1:0] b, input int t, input int s);
        model_t n = mi;
        if (rst) begin
            n.phase = 0; n.wr = 1'b0; n.dir = 1'b0; n.a_out = '0; n.rdata = '0;
        end else if (mi.phase == 0) begin
            if (rq) begin
                n.phase = 1;
                n.wr    = w;
                n.dir   = w;
                if (w) n.a_out = wd;
            end
        end else begin
            // Last enabled cycle is t+s; the chip is driving B onto A then.
            if (mi.phase == t + s && !mi.wr) n.rdata = b;
            n.phase = (mi.phase == 2 * t + s) ? 0 : mi.phase + 1;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m[i] <= step(m[i], reset[i], req[i], write[i], wdata[i], b_drv[i], tp(i), sp(i));
        end
    end

    // ---------------- per-cycle checks ----------------
    logic [1:0]        dir_prev, oe_prev, rst_prev;
    logic [1:0][W-1:0] b_seen;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("busy",  i, 32'(busy[i]), 32'(m[i].phase != 0));
                chk("oe_n",  i, 32'(oe_n[i]),
                    32'(!(m[i].phase > tp(i) && m[i].phase <= tp(i) + sp(i))));
                chk("ack",   i, 32'(ack[i]), 32'(m[i].phase == tp(i) + sp(i) + 1));
                chk("a_oe",  i, 32'(a_oe[i]),
                    32'(m[i].wr && m[i].phase >= 1 && m[i].phase <= tp(i) + sp(i)));
                chk("dir",   i, 32'(dir[i]), 32'(m[i].dir));
                chk("a_out", i, 32'(a_out[i]), 32'(m[i].a_out));
                chk("rdata", i, 32'(rdata[i]), 32'(m[i].rdata));
                chk("contention", i, 32'(a_oe[i] && !oe_n[i] && !dir[i]), 32'(0));
                if (!rst_prev[i] && dir[i] != dir_prev[i]) begin
                    chk("dir_change_enabled", i, 32'(oe_prev[i] && oe_n[i]), 32'(1));
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (!oe_n[i] && dir[i]) b_seen[i] <= a_bus[i];
        end
        dir_prev <= dir;
        oe_prev  <= oe_n;
        rst_prev <= reset;
    end

    // ---------------- directed helpers ----------------
    task automatic run_txn(input int i, input logic w, input logic [W-1:0] wd,
                           input logic [W-1:0] b, output int ack_lat, output int busy_len,
                           output int oe_low, output int aoe_cnt, output int acks);
        b_drv[i] = b; write[i] = w; wdata[i] = wd; req[i] = 1'b1;
        @(posedge clk); #1;
        req[i] = 1'b0;
        ack_lat = -1; busy_len = 0; oe_low = 0; aoe_cnt = 0; acks = 0;
        for (int n = 0; n < 30; n++) begin
            busy_len += int'(busy[i]);
            oe_low   += int'(!oe_n[i]);
            aoe_cnt  += int'(a_oe[i]);
            if (ack[i]) begin
                acks++;
                if (ack_lat < 0) ack_lat = n;
            end
            if (!busy[i]) break;
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic         wr;
        logic [W-1:0] wd;
        logic [W-1:0] b;
        logic [W-1:0] exp_rdata;
        logic [W-1:0] exp_b;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int lat, blen, olow, aoe, acks, cnt;

        tbl[0] = '{1'b1, 8'hA5, 8'h00, 8'h00, 8'hA5};
        tbl[1] = '{1'b0, 8'h00, 8'h3C, 8'h3C, 8'h00};
        tbl[2] = '{1'b1, 8'hF0, 8'h11, 8'h3C, 8'hF0};
        tbl[3] = '{1'b0, 8'hEE, 8'h55, 8'h55, 8'h00};
        tbl[4] = '{1'b1, 8'h0F, 8'h77, 8'h55, 8'h0F};
        tbl[5] = '{1'b0, 8'h00, 8'hC3, 8'hC3, 8'h00};

        reset = '1; req = '0; write = '0; wdata = '0; b_drv = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_oe_n",  i, 32'(oe_n[i]),  32'(1));
            chk("rst_dir",   i, 32'(dir[i]),   32'(0));
            chk("rst_a_oe",  i, 32'(a_oe[i]),  32'(0));
            chk("rst_a_out", i, 32'(a_out[i]), 32'(0));
            chk("rst_rdata", i, 32'(rdata[i]), 32'(0));
            chk("rst_busy",  i, 32'(busy[i]),  32'(0));
            chk("rst_ack",   i, 32'(ack[i]),   32'(0));
        end
        reset = '0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Table: single transactions on the default-timing instance.
        for (int k = 0; k < 6; k++) begin
            run_txn(0, tbl[k].wr, tbl[k].wd, tbl[k].b, lat, blen, olow, aoe, acks);
            chk("tbl_ack_latency", 0, 32'(lat), 32'(4));
            chk("tbl_busy_len",    0, 32'(blen), 32'(5));
            chk("tbl_oe_low",      0, 32'(olow), 32'(3));
            chk("tbl_a_oe_cycles", 0, 32'(aoe), tbl[k].wr ? 32'(4) : 32'(0));
            chk("tbl_ack_count",   0, 32'(acks), 32'(1));
            chk("tbl_rdata",       0, 32'(rdata[0]), 32'(tbl[k].exp_rdata));
            if (tbl[k].wr) chk("tbl_b_seen", 0, 32'(b_seen[0]), 32'(tbl[k].exp_b));
        end

        // Write F0 then read 55 with req held high throughout.
        write[0] = 1'b1; wdata[0] = 8'hF0; b_drv[0] = 8'h55; req[0] = 1'b1;
        acks = 0;
        for (int n = 0; n < 40 && acks < 2; n++) begin
            @(posedge clk); #1;
            if (ack[0]) begin
                acks++;
                if (acks == 1) write[0] = 1'b0;
                else req[0] = 1'b0;
            end
        end
        req[0] = 1'b0;
        chk("b2b_ack_count", 0, 32'(acks), 32'(2));
        for (int n = 0; n < 10 && busy[0]; n++) begin
            @(posedge clk); #1;
        end
        chk("b2b_rdata",  0, 32'(rdata[0]), 32'(8'h55));
        chk("b2b_b_seen", 0, 32'(b_seen[0]), 32'(8'hF0));

        // Reset during the second ACTIVE cycle of a read.
        write[0] = 1'b0; b_drv[0] = 8'h99; req[0] = 1'b1;
        @(posedge clk); #1;  // accepted -> SETUP
        req[0] = 1'b0;
        @(posedge clk); #1;  // ACTIVE 1
        @(posedge clk); #1;  // ACTIVE 2
        chk("rst_mid_pre_oe_n", 0, 32'(oe_n[0]), 32'(0));
        reset[0] = 1'b1;
        @(posedge clk); #1;
        reset[0] = 1'b0;
        chk("rst_mid_oe_n",  0, 32'(oe_n[0]),  32'(1));
        chk("rst_mid_dir",   0, 32'(dir[0]),   32'(0));
        chk("rst_mid_a_oe",  0, 32'(a_oe[0]),  32'(0));
        chk("rst_mid_busy",  0, 32'(busy[0]),  32'(0));
        chk("rst_mid_rdata", 0, 32'(rdata[0]), 32'(0));
        cnt = 0;
        for (int n = 0; n < 6; n++) begin
            cnt += int'(ack[0]);
            @(posedge clk); #1;
        end
        chk("rst_mid_no_ack", 0, 32'(cnt), 32'(0));

        // Extra req pulses while busy are ignored.
        write[0] = 1'b1; wdata[0] = 8'h5A; req[0] = 1'b1;
        @(posedge clk); #1;
        cnt = 0;
        for (int n = 0; n < 12; n++) begin
            cnt += int'(ack[0]);
            write[0] = 1'b0; wdata[0] = 8'hFF;
            req[0] = busy[0] & 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        req[0] = 1'b0;
        chk("ignored_req_acks",  0, 32'(cnt), 32'(1));
        chk("ignored_req_a_out", 0, 32'(a_out[0]), 32'(8'h5A));
        chk("ignored_req_dir",   0, 32'(dir[0]), 32'(1));
        chk("ignored_req_busy",  0, 32'(busy[0]), 32'(0));

        // SETTLE=1, TURNAROUND=2 instance.
        run_txn(1, 1'b1, 8'hC7, 8'h00, lat, blen, olow, aoe, acks);
        chk("p2_w_ack_latency", 1, 32'(lat), 32'(3));
        chk("p2_w_busy_len",    1, 32'(blen), 32'(5));
        chk("p2_w_oe_low",      1, 32'(olow), 32'(1));
        chk("p2_w_b_seen",      1, 32'(b_seen[1]), 32'(8'hC7));
        run_txn(1, 1'b0, 8'h00, 8'h2E, lat, blen, olow, aoe, acks);
        chk("p2_r_busy_len",    1, 32'(blen), 32'(5));
        chk("p2_r_oe_low",      1, 32'(olow), 32'(1));
        chk("p2_r_a_oe",        1, 32'(aoe), 32'(0));
        chk("p2_r_rdata",       1, 32'(rdata[1]), 32'(8'h2E));

        // Random traffic on both instances, checked against the model every cycle.
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 2; i++) begin
                req[i]   = ($urandom_range(0, 2) == 0);
                write[i] = 1'($urandom_range(0, 1));
                wdata[i] = W'($urandom);
                b_drv[i] = W'($urandom);
                reset[i] = ($urandom_range(0, 59) == 0);
            end
            @(posedge clk); #1;
        end
        req = '0; reset = '0;
        repeat (12) @(posedge clk);
        #1;
        chk("end_idle", 0, 32'(busy), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
